rf_mp_scoreboard: RTL and testbench

Next-generation integer register file for the RISC core.
- Parametrised read-port count, data width and depth.
- Two write ports: ALU writeback (port 0) and late load return (port 1).
- Register 0 hard-wired to zero.
- Per-register pending scoreboard, so issue logic can detect RAW hazards on outstanding results.
- Sits between decode (reads and issue) and the writeback/load-return stages.

---
 rtl/rf_pkg.sv | 30 +++
 rtl/rf_scoreboard.sv | 68 ++++++
 rtl/rf_mp_scoreboard.sv | 141 ++++++++++++++
 tb/tb_rf_mp_scoreboard.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared constants and types for the multi-port integer register file and its
// pending-result scoreboard.
//   DEF_*       default geometry (32 x 32-bit, two read ports)
//   NUM_WR      number of write ports
//   WB_PORT     index of the ALU writeback port
//   LD_PORT     index of the load-return port. It is the higher index, so it
//               wins a same-address collision.
//   reg_addr_t  architectural register index at default geometry
//   reg_data_t  register contents at default geometry
//   ZERO_REG    the hard-wired zero register
// -----------------------------------------------------------------------------
package rf_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ADDR_DEPTH = 32;
  localparam int unsigned DEF_ADDR_WIDTH = 5;
  localparam int unsigned DEF_NUM_RD     = 2;

  localparam int unsigned NUM_WR  = 2;
  localparam int unsigned WB_PORT = 0;
  localparam int unsigned LD_PORT = 1;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;
  typedef logic [DEF_DATA_WIDTH-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage : rf_pkg

// File: rtl/rf_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_scoreboard
// Keeps one pending bit per architectural register. A pending bit marks an
// issued producer whose result has not been written back yet.
// Priority applied at each rising edge, from lowest to highest:
//   1. A write on either port clears the pending bit of its address.
//   2. An issue sets the pending bit of its destination. The set wins over a
//      clear because the new producer is younger.
//   3. A flush clears every pending bit.
// Bit 0 (the zero register) is never pending.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   iss_valid    an instruction with a destination issues this cycle
//   iss_rd       destination register of that instruction
//   clr_en       per write port: write enable
//   clr_addr     per write port: write address
//   flush        pipeline flush
//   pend         pending vector (registered)
//   any_busy     OR of pend
// -----------------------------------------------------------------------------
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_DEPTH = DEF_ADDR_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               iss_valid,
  input  logic [ADDR_WIDTH-1:0]              iss_rd,
  input  logic [NUM_WR-1:0]                  clr_en,
  input  logic [NUM_WR-1:0][ADDR_WIDTH-1:0]  clr_addr,
  input  logic                               flush,
  output logic [ADDR_DEPTH-1:0]              pend,
  output logic                               any_busy
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_REG);

  logic [ADDR_DEPTH-1:0] pend_q;
  logic [ADDR_DEPTH-1:0] pend_nxt;

  // The order of the statements below encodes the priority:
  // clear < set < flush.
  always_comb begin
    // NOTE: every variable assigned in always_comb gets a full default first,
    // so that no path leaves it unassigned and no latch is inferred.
    pend_nxt = pend_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (clr_en[p]) pend_nxt[clr_addr[p]] = 1'b0;
    end
    if (iss_valid && iss_rd != ZERO_A) pend_nxt[iss_rd] = 1'b1;
    if (flush) pend_nxt = '0;
    pend_nxt[ZERO_A] = 1'b0;
  end

  // NOTE: clocked state uses non-blocking assignments only. Combinational
  // blocks use blocking assignments, so that later statements see the
  // updated value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_nxt;
  end

  assign pend     = pend_q;
  assign any_busy = |pend_q;

endmodule : rf_scoreboard

// File: rtl/rf_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// rf_mp_scoreboard
// Integer register file with NUM_RD combinational read ports, two write ports
// and a per-register pending scoreboard for RAW hazard detection.
// Register 0 always reads as zero and is never pending.
// Build option:
//   RF_BYPASS_EN  When defined, a same-cycle write is forwarded to a read of the
//                 same address. Port 1 (load) has priority over port 0. A
//                 forwarded read reports not busy, unless an instruction is
//                 issuing to that address in the same cycle.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   rd_addr       read addresses, port k in slice k
//   rd_data       read data, port k in slice k
//   rd_busy       per read port: the addressed register has an outstanding
//                 producer
//   we0/wa0/wd0   ALU writeback write port
//   we1/wa1/wd1   load-return write port. It wins a same-address collision.
//   iss_valid     an instruction with a destination issues this cycle
//   iss_rd        its destination register
//   flush         clears all pending bits; register writes still happen
//   any_busy      some register is pending (drain detection)
// -----------------------------------------------------------------------------
module rf_mp_scoreboard
  import rf_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_DEPTH = DEF_ADDR_DEPTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned NUM_RD     = DEF_NUM_RD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         we0,
  input  logic [ADDR_WIDTH-1:0]        wa0,
  input  logic [DATA_WIDTH-1:0]        wd0,
  input  logic                         we1,
  input  logic [ADDR_WIDTH-1:0]        wa1,
  input  logic [DATA_WIDTH-1:0]        wd1,
  input  logic                         iss_valid,
  input  logic [ADDR_WIDTH-1:0]        iss_rd,
  input  logic                         flush,
  output logic                         any_busy
);

  localparam logic [ADDR_WIDTH-1:0] ZERO_A = ADDR_WIDTH'(ZERO_REG);

  // Write ports gathered into arrays indexed by port number.
  logic [NUM_WR-1:0]                 we;
  logic [NUM_WR-1:0][ADDR_WIDTH-1:0] wa;
  logic [NUM_WR-1:0][DATA_WIDTH-1:0] wd;

  assign we[WB_PORT] = we0;
  assign wa[WB_PORT] = wa0;
  assign wd[WB_PORT] = wd0;
  assign we[LD_PORT] = we1;
  assign wa[LD_PORT] = wa1;
  assign wd[LD_PORT] = wd1;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem [ADDR_DEPTH];

  // Ports are visited in ascending order. On an address collision the later
  // non-blocking assignment (LD_PORT) is the one that takes effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: this array is built from flops and must read zero right after
      // reset, so every entry is reset. That also rules out mapping it onto a
      // RAM macro.
      mem <= '{default: '0};
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (we[p] && wa[p] != ZERO_A) mem[wa[p]] <= wd[p];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [ADDR_DEPTH-1:0] pend;

  rf_scoreboard #(
    .ADDR_DEPTH (ADDR_DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .clr_en    (we),
    .clr_addr  (wa),
    .flush     (flush),
    .pend      (pend),
    .any_busy  (any_busy)
  );

  // ---------------------------------------------------------------------------
  // Read ports
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] stored;

    assign addr   = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign stored = (addr == ZERO_A) ? '0 : mem[addr];

`ifdef RF_BYPASS_EN
    logic hit_wb;
    logic hit_ld;
    logic reissue;

    assign hit_ld  = we1 && wa1 == addr && addr != ZERO_A;
    assign hit_wb  = we0 && wa0 == addr && addr != ZERO_A;
    // A forwarded value is final unless a younger producer issues to the
    // same register in this cycle.
    assign reissue = iss_valid && iss_rd == addr;

    always_comb begin
      rd_data[k*DATA_WIDTH +: DATA_WIDTH] = stored;
      rd_busy[k]                          = pend[addr];
      if (hit_ld) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wd1;
        rd_busy[k]                          = reissue;
      end else if (hit_wb) begin
        rd_data[k*DATA_WIDTH +: DATA_WIDTH] = wd0;
        rd_busy[k]                          = reissue;
      end
    end
`else
    assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = stored;
    assign rd_busy[k]                          = pend[addr];
`endif
  end : g_rd

endmodule : rf_mp_scoreboard

// File: tb/tb_rf_mp_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_rf_mp_scoreboard
// Self-checking bench for rf_mp_scoreboard at its default geometry (32 x 32,
// two read ports). Directed scenarios are followed by randomized traffic, with
// an asynchronous reset in the middle. Every cycle is compared against an
// array-based reference model. Compile with +define+RF_BYPASS_EN to check the
// forwarding build.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rf_mp_scoreboard;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        flush;
  logic        any_busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: architectural contents plus outstanding producers.
  reg_data_t m_reg  [32];
  bit        m_pend [32];

  always #5 clk = ~clk;

  rf_mp_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .we0       (we0),
    .wa0       (wa0),
    .wd0       (wd0),
    .we1       (we1),
    .wa1       (wa1),
    .wd1       (wd1),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .any_busy  (any_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    else             n_pass++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  // Value a reader must see this cycle, given the current write inputs.
  function automatic logic [31:0] exp_data(input logic [4:0] a);
    if (a == 0) return 32'h0;
`ifdef RF_BYPASS_EN
    if (we1 && wa1 == a) return wd1;
    if (we0 && wa0 == a) return wd0;
`endif
    return m_reg[a];
  endfunction

  function automatic logic exp_busy(input logic [4:0] a);
    if (a == 0) return 1'b0;
`ifdef RF_BYPASS_EN
    if ((we1 && wa1 == a) || (we0 && wa0 == a)) return iss_valid && iss_rd == a;
`endif
    return m_pend[a];
  endfunction

  function automatic logic exp_any();
    logic r = 1'b0;
    for (int i = 0; i < 32; i++) r |= m_pend[i];
    return r;
  endfunction

  task automatic idle();
    we0 = 0; wa0 = '0; wd0 = '0;
    we1 = 0; wa1 = '0; wd1 = '0;
    iss_valid = 0; iss_rd = '0; flush = 0;
  endtask

  task automatic set_rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  // Waits for the falling edge, then compares every output with the model.
  task automatic compare();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      logic [4:0] a;
      a = rd_addr[k*5 +: 5];
      check($sformatf("rd_data%0d@%0d", k, a), rd_data[k*32 +: 32], exp_data(a));
      check($sformatf("rd_busy%0d@%0d", k, a), 32'(rd_busy[k]), 32'(exp_busy(a)));
    end
    check("any_busy", 32'(any_busy), 32'(exp_any()));
  endtask

  // Advances the model across one rising edge, then returns just after it.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (we0 && wa0 != 0) m_reg[wa0] = wd0;
      if (we1 && wa1 != 0) m_reg[wa1] = wd1;
      if (flush) begin
        for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
        if (we0) m_pend[wa0] = 1'b0;
        if (we1) m_pend[wa1] = 1'b0;
        if (iss_valid && iss_rd != 0) m_pend[iss_rd] = 1'b1;
      end
    end
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 1) == 0) return 5'($urandom_range(0, 7));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    model_reset();
    tick();
    tick();
    compare();
    rst_n = 1'b1;
    tick();

    // Register 0: writes and issues to it have no effect.
    we0 = 1; wa0 = 5'd0; wd0 = 32'hDEAD_BEEF;
    iss_valid = 1; iss_rd = 5'd0;
    set_rd(5'd0, 5'd0);
    compare();
    check("zero_data_same", rd_data[31:0], 32'h0);
    tick();
    idle();
    compare();
    check("zero_data", rd_data[31:0], 32'h0);
    check("zero_busy", 32'(rd_busy[0]), 32'h0);

    // Both ports write register 5: the load data is stored.
    tick();
    we0 = 1; wa0 = 5'd5; wd0 = 32'h11;
    we1 = 1; wa1 = 5'd5; wd1 = 32'h22;
    compare();
    tick();
    idle();
    set_rd(5'd5, 5'd0);
    compare();
    check("dual_write", rd_data[31:0], 32'h22);

    // Scoreboard lifecycle on register 7.
    tick();
    iss_valid = 1; iss_rd = 5'd7;
    compare();
    tick();
    idle();
    set_rd(5'd7, 5'd7);
    compare();
    check("sb7_set", 32'(rd_busy[0]), 32'h1);
    tick();
    we1 = 1; wa1 = 5'd7; wd1 = 32'h77;
    compare();
    tick();
    idle();
    compare();
    check("sb7_clear", 32'(rd_busy[0]), 32'h0);
    check("sb7_data", rd_data[31:0], 32'h77);
    tick();
    iss_valid = 1; iss_rd = 5'd7;
    compare();
    tick();
    idle();
    iss_valid = 1; iss_rd = 5'd7;
    we0 = 1; wa0 = 5'd7; wd0 = 32'h7070;
    compare();
    tick();
    idle();
    compare();
    check("sb7_set_wins", 32'(rd_busy[0]), 32'h1);
    tick();
    we0 = 1; wa0 = 5'd7; wd0 = 32'h7171;
    compare();
    tick();
    idle();

    // Flush clears every pending bit and overrides a simultaneous issue.
    iss_valid = 1; iss_rd = 5'd3; compare(); tick();
    iss_valid = 1; iss_rd = 5'd4; compare(); tick();
    iss_valid = 1; iss_rd = 5'd9; compare(); tick();
    idle();
    set_rd(5'd3, 5'd9);
    compare();
    check("pend_before_flush", 32'(any_busy), 32'h1);
    tick();
    flush = 1; iss_valid = 1; iss_rd = 5'd10;
    we0 = 1; wa0 = 5'd3; wd0 = 32'h333;
    compare();
    tick();
    idle();
    set_rd(5'd10, 5'd3);
    compare();
    check("flush_any", 32'(any_busy), 32'h0);
    check("flush_busy10", 32'(rd_busy[0]), 32'h0);
    check("flush_write_lands", rd_data[63:32], 32'h333);
    tick();

    // Same-cycle read of a register being written.
    we0 = 1; wa0 = 5'd12; wd0 = 32'h1234;
    compare();
    tick();
    idle();
    we0 = 1; wa0 = 5'd12; wd0 = 32'hABCD;
    set_rd(5'd12, 5'd0);
    compare();
`ifdef RF_BYPASS_EN
    check("same_cycle_read", rd_data[31:0], 32'hABCD);
`else
    check("same_cycle_read", rd_data[31:0], 32'h1234);
`endif
    tick();
    idle();
    compare();
    check("after_write", rd_data[31:0], 32'hABCD);
    tick();

    // Randomized traffic with an asynchronous reset in the middle.
    for (int i = 0; i < 400; i++) begin
      we0 = 1'($urandom_range(0, 1)); wa0 = rand_addr(); wd0 = $urandom();
      we1 = 1'($urandom_range(0, 1)); wa1 = rand_addr(); wd1 = $urandom();
      iss_valid = 1'($urandom_range(0, 1)); iss_rd = rand_addr();
      flush = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 2) == 0) set_rd(wa0, wa1);
      else                           set_rd(rand_addr(), rand_addr());

      if (i == 200) begin
        // Reset lands while writes are still being driven. Those writes must
        // be discarded.
        we0 = 1; wa0 = 5'd13; we1 = 1; wa1 = 5'd14;
        iss_valid = 1; iss_rd = 5'd15;
        #2;
        rst_n = 1'b0;
        model_reset();
        tick();
        idle();
        for (int a = 0; a < 32; a++) begin
          set_rd(5'(a), 5'(31 - a));
          compare();
          tick();
        end
        rst_n = 1'b1;
        tick();
      end else begin
        compare();
        tick();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_rf_mp_scoreboard
